// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - 4-bit instruction decoder: machine-cycle phase counter, OPR/OPA latch, two-word fetch, write strobes (optional INST_DECODER_ILLEGAL_EN)
module inst_decoder (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] romNibble_i,
    input  logic       hold_i,
    output logic [2:0] phase_o,
    output logic       sync_o,
    output logic [3:0] aluOp_o,
    output logic [3:0] aluSubOp_o,
    output logic [3:0] opaOut_o,
    output logic       twoWord_o,
    output logic [7:0] immData_o,
    output logic       accWe_o,
    output logic       carryWe_o,
    output logic       regWe_o,
    output logic       pcInc_o,
    output logic       jumpReq_o,
    output logic       illegalOp_o
);

    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    logic [2:0] phase_q, phase_d;
    logic [3:0] opr_q, opr_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [3:0] alu_sub_q, alu_sub_d;
    logic [7:0] imm_q, imm_d;
    logic       two_word_q, two_word_d;

    logic at_m1, at_m2, at_x3;
    logic first_is_two;
    logic completes;
    logic x2_fire;
    logic acc_dec, carry_dec, reg_dec, ill_dec;

    // Phase counter state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 3'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state: advance and wrap unless held
    always_comb begin
        phase_d = phase_q;
        if (!hold_i) begin
            phase_d = phase_q + 3'd1;
        end
    end

    // Instruction, immediate and two-word registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opr_q      <= 4'd0;
            opa_q      <= 4'd0;
            alu_op_q   <= 4'd0;
            alu_sub_q  <= 4'd0;
            imm_q      <= 8'd0;
            two_word_q <= 1'b0;
        end else begin
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            alu_op_q   <= alu_op_d;
            alu_sub_q  <= alu_sub_d;
            imm_q      <= imm_d;
            two_word_q <= two_word_d;
        end
    end

    // Capture nibbles at M1/M2; a second word goes to immData, a first word to OPR/OPA
    always_comb begin
        at_m1      = !hold_i && (phase_q == PH_M1);
        at_m2      = !hold_i && (phase_q == PH_M2);
        at_x3      = !hold_i && (phase_q == PH_X3);
        opr_d      = opr_q;
        opa_d      = opa_q;
        alu_op_d   = alu_op_q;
        alu_sub_d  = alu_sub_q;
        imm_d      = imm_q;
        two_word_d = two_word_q;
        if (at_m1) begin
            if (two_word_q) begin
                imm_d[7:4] = romNibble_i;
            end else begin
                opr_d = romNibble_i;
            end
        end
        // The M2 edge is also the X1 edge, so the ALU sees OPA in the same clock it is latched
        if (at_m2) begin
            if (two_word_q) begin
                imm_d[3:0] = romNibble_i;
            end else begin
                opa_d     = romNibble_i;
                alu_op_d  = opr_q;
                alu_sub_d = romNibble_i;
            end
        end
        // A second-word cycle always returns to single-word fetch
        if (at_x3) begin
            two_word_d = !two_word_q && first_is_two;
        end
    end

    // Opcode decode of the executing instruction
    always_comb begin
        first_is_two = 1'b0;
        acc_dec      = 1'b0;
        carry_dec    = 1'b0;
        reg_dec      = 1'b0;
        ill_dec      = 1'b0;
        case (alu_op_q)
            4'h1, 4'h4, 4'h5: first_is_two = 1'b1;
            4'h2: begin
                first_is_two = !alu_sub_q[0];
                reg_dec      = !alu_sub_q[0];
            end
            4'h6: reg_dec = 1'b1;
            4'h7: begin
                first_is_two = 1'b1;
                reg_dec      = 1'b1;
            end
            4'h8, 4'h9: begin
                acc_dec   = 1'b1;
                carry_dec = 1'b1;
            end
            4'hA, 4'hC, 4'hD: acc_dec = 1'b1;
            4'hB: begin
                acc_dec = 1'b1;
                reg_dec = 1'b1;
            end
            4'hE: begin
                acc_dec   = alu_sub_q[3];
                carry_dec = (alu_sub_q == 4'h8) || (alu_sub_q == 4'hB);
            end
            4'hF: begin
                acc_dec   = (alu_sub_q <= 4'hC);
                carry_dec = (alu_sub_q <= 4'hB) && (alu_sub_q != 4'h4);
                ill_dec   = (alu_sub_q >= 4'hE);
            end
            default: begin
                first_is_two = 1'b0;
            end
        endcase
    end

    // Strobe and status outputs, every strobe gated by hold
    always_comb begin
        completes  = two_word_q || !first_is_two;
        x2_fire    = !hold_i && (phase_q == PH_X2) && completes;
        phase_o    = phase_q;
        sync_o     = (phase_q == PH_X3);
        aluOp_o    = alu_op_q;
        aluSubOp_o = alu_sub_q;
        opaOut_o   = alu_sub_q;
        twoWord_o  = two_word_q;
        immData_o  = imm_q;
        accWe_o    = x2_fire && acc_dec && !ill_dec;
        carryWe_o  = x2_fire && carry_dec && !ill_dec;
        regWe_o    = x2_fire && reg_dec;
        pcInc_o    = !hold_i && (phase_q == PH_X3);
        jumpReq_o  = !hold_i && (phase_q == PH_X3) && two_word_q &&
                     ((alu_op_q == 4'h4) || (alu_op_q == 4'h5));
`ifdef INST_DECODER_ILLEGAL_EN
        illegalOp_o = x2_fire && ill_dec;
`else
        illegalOp_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_inst_decoder.sv
// tb/tb_inst_decoder.sv - self-checking bench for inst_decoder
module tb_inst_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] romNibble;
    logic       hold;
    logic [2:0] phase;
    logic       sync;
    logic [3:0] aluOp, aluSubOp, opaOut;
    logic       twoWord;
    logic [7:0] immData;
    logic       accWe, carryWe, regWe, pcInc, jumpReq, illegalOp;

    int total = 0;
    int bad   = 0;
    int jmp_seen = 0;

    inst_decoder dut (
        .clk_i(clk), .rst_ni(rst_n), .romNibble_i(romNibble), .hold_i(hold),
        .phase_o(phase), .sync_o(sync), .aluOp_o(aluOp), .aluSubOp_o(aluSubOp),
        .opaOut_o(opaOut), .twoWord_o(twoWord), .immData_o(immData),
        .accWe_o(accWe), .carryWe_o(carryWe), .regWe_o(regWe), .pcInc_o(pcInc),
        .jumpReq_o(jumpReq), .illegalOp_o(illegalOp)
    );

    always #5 clk = ~clk;

    // Opcode property tables: bit n set means opcode/operand n has the property
    localparam logic [15:0] OPR_ACC   = 16'h3F00;
    localparam logic [15:0] F_ACC     = 16'h1FFF;
    localparam logic [15:0] E_ACC     = 16'hFF00;
    localparam logic [15:0] OPR_CARRY = 16'h0300;
    localparam logic [15:0] F_CARRY   = 16'h0FEF;
    localparam logic [15:0] E_CARRY   = 16'h0900;
    localparam logic [15:0] OPR_REG   = 16'h08C0;
    localparam logic [15:0] OPR_TWO   = 16'h00B2;

    function automatic logic is_fim(input logic [3:0] hi, input logic [3:0] lo);
        return (hi == 4'h2) && (lo % 2 == 0);
    endfunction

    function automatic logic needs2(input logic [3:0] hi, input logic [3:0] lo);
        logic [15:0] t;
        t = OPR_TWO;
        return t[hi] || is_fim(hi, lo);
    endfunction

    function automatic logic is_illegal(input logic [3:0] hi, input logic [3:0] lo);
`ifdef INST_DECODER_ILLEGAL_EN
        return (hi == 4'hF) && (lo >= 4'hE);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_acc(input logic [3:0] hi, input logic [3:0] lo);
        logic [15:0] a, f, e;
        a = OPR_ACC; f = F_ACC; e = E_ACC;
        return a[hi] || (hi == 4'hF && f[lo]) || (hi == 4'hE && e[lo]);
    endfunction

    function automatic logic exp_carry(input logic [3:0] hi, input logic [3:0] lo);
        logic [15:0] a, f, e;
        a = OPR_CARRY; f = F_CARRY; e = E_CARRY;
        return a[hi] || (hi == 4'hF && f[lo]) || (hi == 4'hE && e[lo]);
    endfunction

    function automatic logic exp_reg(input logic [3:0] hi, input logic [3:0] lo);
        logic [15:0] a;
        a = OPR_REG;
        return a[hi] || is_fim(hi, lo);
    endfunction

    // Reference model: phase number, which word of the instruction is being fetched, executing instruction
    int         m_ph;
    logic       m_second;
    logic [3:0] m_fhi, m_xhi, m_xlo;
    logic [7:0] m_imm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_second <= 1'b0; m_fhi <= 4'h0;
            m_xhi <= 4'h0; m_xlo <= 4'h0; m_imm <= 8'h00;
        end else if (!hold) begin
            m_ph <= (m_ph + 1) % 8;
            if (m_ph == 3) begin
                if (m_second) m_imm[7:4] <= romNibble;
                else m_fhi <= romNibble;
            end
            if (m_ph == 4) begin
                if (m_second) m_imm[3:0] <= romNibble;
                else begin m_xhi <= m_fhi; m_xlo <= romNibble; end
            end
            if (m_ph == 7) m_second <= !m_second && needs2(m_xhi, m_xlo);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        logic done, x2, x3;
        done = m_second || !needs2(m_xhi, m_xlo);
        x2   = !hold && m_ph == 6 && done;
        x3   = !hold && m_ph == 7;
        if (jumpReq === 1'b1) jmp_seen++;
        check("phase",    32'(phase),    32'(m_ph));
        check("sync",     32'(sync),     32'(m_ph == 7));
        check("aluOp",    32'(aluOp),    32'(m_xhi));
        check("aluSubOp", 32'(aluSubOp), 32'(m_xlo));
        check("opaOut",   32'(opaOut),   32'(m_xlo));
        check("twoWord",  32'(twoWord),  32'(m_second));
        check("immData",  32'(immData),  32'(m_imm));
        check("accWe",    32'(accWe),    32'(x2 && exp_acc(m_xhi, m_xlo) && !is_illegal(m_xhi, m_xlo)));
        check("carryWe",  32'(carryWe),  32'(x2 && exp_carry(m_xhi, m_xlo) && !is_illegal(m_xhi, m_xlo)));
        check("regWe",    32'(regWe),    32'(x2 && exp_reg(m_xhi, m_xlo)));
        check("pcInc",    32'(pcInc),    32'(x3));
        check("jumpReq",  32'(jumpReq),  32'(x3 && m_second && (m_xhi == 4'h4 || m_xhi == 4'h5)));
        check("illegalOp", 32'(illegalOp), 32'(x2 && is_illegal(m_xhi, m_xlo)));
    end

    // Per-phase samples of the last machine cycle driven
    logic [3:0] s_alu[8], s_sub[8];
    logic [7:0] s_imm[8];
    logic       s_acc[8], s_car[8], s_reg[8], s_pc[8], s_jmp[8], s_two[8], s_ill[8];
    int         acc_cnt;
    logic       hold_ok;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one machine cycle starting at A1; optional hold of hold_n clocks at X2
    task automatic do_cycle(input logic [3:0] hi, input logic [3:0] lo, input int hold_n);
        acc_cnt = 0;
        hold_ok = 1'b1;
        for (int p = 0; p < 8; p++) begin
            romNibble = (p == 4) ? lo : hi;
            if (p == 6) begin
                for (int h = 0; h < hold_n; h++) begin
                    hold = 1'b1;
                    #1;
                    if (phase !== 3'd6) hold_ok = 1'b0;
                    if (accWe === 1'b1) acc_cnt++;
                    step();
                end
            end
            hold = 1'b0;
            #1;
            s_alu[p] = aluOp; s_sub[p] = aluSubOp; s_imm[p] = immData;
            s_acc[p] = accWe; s_car[p] = carryWe; s_reg[p] = regWe;
            s_pc[p] = pcInc; s_jmp[p] = jumpReq; s_two[p] = twoWord; s_ill[p] = illegalOp;
            if (p == 6 && accWe === 1'b1) acc_cnt++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int j0;
        rst_n = 1'b0; hold = 1'b0; romNibble = 4'h0;
        repeat (3) step();
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_two",   32'(twoWord), 32'd0);
        check("rst_imm",   32'(immData), 32'd0);
        check("rst_alu",   32'(aluOp), 32'd0);
        check("rst_pc",    32'(pcInc), 32'd0);
        rst_n = 1'b1;

        // ADD R3
        do_cycle(4'h8, 4'h3, 0);
        check("add_aluOp",  32'(s_alu[5]), 32'h8);
        check("add_aluSub", 32'(s_sub[5]), 32'h3);
        check("add_acc",    32'(s_acc[6]), 32'd1);
        check("add_carry",  32'(s_car[6]), 32'd1);
        check("add_pc",     32'(s_pc[7]),  32'd1);
        check("add_jmp",    32'(s_jmp[7]), 32'd0);

        // JUN 0x123
        do_cycle(4'h4, 4'h1, 0);
        check("jun1_acc", 32'(s_acc[6]), 32'd0);
        check("jun1_pc",  32'(s_pc[7]),  32'd1);
        check("jun1_jmp", 32'(s_jmp[7]), 32'd0);
        do_cycle(4'h2, 4'h3, 0);
        check("jun2_two", 32'(s_two[0]), 32'd1);
        check("jun2_imm", 32'(s_imm[5]), 32'h23);
        check("jun2_alu", 32'(s_alu[5]), 32'h4);
        check("jun2_jmp", 32'(s_jmp[7]), 32'd1);

        // CLB with hold at X2
        do_cycle(4'hF, 4'h0, 3);
        check("clb_hold_phase", 32'(hold_ok), 32'd1);
        check("clb_acc_pulses", 32'(acc_cnt), 32'd1);

        // FIM P2, 0x5A, then SRC
        do_cycle(4'h2, 4'h4, 0);
        do_cycle(4'h5, 4'hA, 0);
        check("fim_two", 32'(s_two[3]), 32'd1);
        check("fim_imm", 32'(s_imm[5]), 32'h5A);
        check("fim_reg", 32'(s_reg[6]), 32'd1);
        do_cycle(4'h2, 4'h5, 0);
        do_cycle(4'h0, 4'h0, 0);
        check("src_two", 32'(s_two[2]), 32'd0);
        check("nop_acc", 32'(s_acc[6] | s_car[6] | s_reg[6]), 32'd0);

        // Assorted opcodes, including ISZ two-word and boundary operands
        do_cycle(4'h6, 4'h2, 0);
        do_cycle(4'hE, 4'h8, 0);
        do_cycle(4'hE, 4'hB, 0);
        do_cycle(4'hE, 4'h7, 0);
        do_cycle(4'hF, 4'hC, 0);
        do_cycle(4'hF, 4'hD, 0);
        do_cycle(4'hF, 4'h4, 0);
        do_cycle(4'hB, 4'h5, 0);
        do_cycle(4'h7, 4'h3, 0);
        do_cycle(4'h0, 4'h9, 0);
        check("isz_reg", 32'(s_reg[6]), 32'd1);
        do_cycle(4'h1, 4'h2, 0);
        do_cycle(4'h3, 4'h4, 0);

        // JMS abandoned by reset at M1 of the second word
        do_cycle(4'h5, 4'h0, 0);
        j0 = jmp_seen;
        for (int p = 0; p < 3; p++) begin
            romNibble = 4'h1;
            step();
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_mid_phase", 32'(phase), 32'd0);
        check("rst_mid_two",   32'(twoWord), 32'd0);
        check("rst_mid_imm",   32'(immData), 32'd0);
        check("rst_mid_jmp",   32'(jmp_seen), 32'(j0));

        // Unassigned F,E
        do_cycle(4'hF, 4'hE, 0);
`ifdef INST_DECODER_ILLEGAL_EN
        check("fe_ill", 32'(s_ill[6]), 32'd1);
`else
        check("fe_ill", 32'(s_ill[6]), 32'd0);
`endif
        check("fe_acc", 32'(s_acc[6]), 32'd0);
        check("fe_pc",  32'(s_pc[7]),  32'd1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 romNibble  in  4  instruction nibble from program ROM; sampled at M1 (OPR) and M2 (OPA).
REQ-004 hold  in  1  freezes the phase counter and suppresses all strobes while high.
REQ-005 phase  out  3  current machine phase: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
REQ-006 sync  out  1  high while phase==X3; marks the end of a machine cycle.
REQ-007 aluOp  out  4  latched OPR of the executing instruction, driven to the ALU.
REQ-008 aluSubOp  out  4  latched OPA of the executing instruction, driven to the ALU.
REQ-009 opaOut  out  4  same value as aluSubOp; feeds register-index and immediate paths.
REQ-010 twoWord  out  1  high for the whole machine cycle that fetches a second instruction word.
REQ-011 immData  out  8  second word {OPR2,OPA2}; valid from the X1 of the second-word cycle until the next second-word capture.
REQ-012 accWe, carryWe, regWe  out  1 each  single-clock write strobes at X2.
REQ-013 pcInc  out  1  single-clock strobe at X3.
REQ-014 jumpReq  out  1  single-clock strobe at X3 that ends a JUN or JMS.
REQ-015 illegalOp  out  1  single-clock strobe at X2; present only with the configuration macro (REQ-033).

Function
REQ-016 The phase counter SHALL advance by 1 per clock when hold=0, wrap from 7 to 0, and hold its value when hold=1.
REQ-017 At M1, when twoWord=0, the block SHALL latch romNibble into OPR; at M2, when twoWord=0, it SHALL latch romNibble into OPA.
REQ-018 At M1 and M2, when twoWord=1, the block SHALL latch romNibble into immData[7:4] and immData[3:0] respectively, and SHALL leave OPR and OPA unchanged.
REQ-019 aluOp and aluSubOp SHALL be updated from OPR and OPA on the X1 edge, and SHALL be held through A1..M2 of the following cycle and through the whole second-word cycle.
REQ-020 twoWord SHALL be set at the end of X3 when the first word has OPR in {1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or OPR=2 with OPA[0]=0 (FIM); otherwise it SHALL be cleared at the end of X3.
REQ-021 The X2 strobes SHALL be issued only in the cycle that completes an instruction: the single cycle of a one-word instruction, or the second-word cycle of a two-word instruction.
REQ-022 accWe SHALL be asserted for:
- OPR in {8, 9, A, B, C, D};
- OPR=F with OPA 0..C;
- OPR=E with OPA 8..F.
REQ-023 carryWe SHALL be asserted for:
- OPR in {8, 9};
- OPR=F with OPA in {0,1,2,3,5,6,7,8,9,A,B};
- OPR=E with OPA in {8, B}.
REQ-024 regWe SHALL be asserted for OPR in {6 INC, 7 ISZ, B XCH}, and for OPR=2 with OPA[0]=0 (FIM).
REQ-025 pcInc SHALL be asserted at every X3, including second-word cycles.
REQ-026 jumpReq SHALL be asserted at X3 of the second-word cycle of JUN or JMS.
REQ-027 Every strobe SHALL be gated with !hold, so that a strobe lasts exactly one clock even if hold toggles.
REQ-028 OPR=0 (NOP) SHALL produce no write strobe and SHALL produce pcInc only.

Reset
REQ-029 While rst_n=0, the block SHALL drive:
- phase=A1 (0), sync=0;
- OPR, OPA, aluOp, aluSubOp, opaOut = 0;
- immData=0, twoWord=0;
- all strobes = 0.
REQ-030 Reset asserted mid-cycle or mid-second-word SHALL abandon the instruction, with no strobe issued.
REQ-031 After rst_n deasserts, the first fetch SHALL begin at A1 on the next rising edge.

Configuration
REQ-032 The macro INST_DECODER_ILLEGAL_EN SHALL control illegal-opcode detection.
REQ-033 With INST_DECODER_ILLEGAL_EN defined, for OPR=F with OPA in {E, F}:
- illegalOp SHALL pulse at X2;
- accWe and carryWe SHALL be suppressed.
REQ-034 Without INST_DECODER_ILLEGAL_EN:
- illegalOp SHALL be tied to 0;
- OPR=F with OPA in {E, F} SHALL behave as NOP.

Verification
REQ-035 Reset, then feed nibbles 8,3 (ADD R3) -> at X1 aluOp=8, aluSubOp=3; at X2 accWe=1 and carryWe=1; pcInc at X3; no jumpReq.
REQ-036 Feed 4,1 then 2,3 (JUN 0x123) -> first cycle has no strobes except pcInc; second cycle has twoWord=1, immData=0x23, aluOp=4 held, and jumpReq=1 at X3.
REQ-037 Feed F,0 (CLB) with hold=1 asserted for 3 clocks at X2 -> phase stays 6 during hold; accWe pulses exactly once, on the first clock after hold drops.
REQ-038 Feed 2,4 (FIM P2) then 5,A -> twoWord=1, immData=0x5A, regWe at X2 of the second cycle; then feed 2,5 (SRC) -> twoWord stays 0.
REQ-039 Feed 5,0, then pulse rst_n=0 at M1 of the second-word cycle -> no jumpReq; after reset phase=0, twoWord=0, immData=0.
REQ-040 Feed F,E with the macro defined -> illegalOp=1 at X2 and accWe=0; without the macro -> illegalOp=0 and pcInc only.
